mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator-side controller that owns a single-port synchronous RAM, i.e. a register array with ports we/add/wr/rd and 1-cycle registered read latency.
- Copies a block of len words from src to dst using memmove semantics, so overlapping regions are copied correctly.
- Sits between the Neptune control unit and the general-purpose RAM. It is the requester driving the RAM's we/add/wr and consuming its rd.

Parameters:
- width, 16: RAM word width.
- add_width, 13: RAM address width. The address space is 2^add_width words; all address arithmetic is modulo 2^add_width.

Ports:
- clk  input  1  System clock.
- rst  input  1  Reset. Synchronous, active-high; one clock; all state updates on posedge clk.
- start  input  1  Copy request. Sampled only in IDLE.
- src  input  add_width  Source base address. Sampled with start.
- dst  input  add_width  Destination base address. Sampled with start.
- len  input  add_width  Word count. 0 = no-op.
- busy  output  1  High in RD/WR states.
- done  output  1  One-cycle pulse when the copy finishes.
- mem_we  output  1  RAM write enable.
- mem_add  output  add_width  RAM address.
- mem_wr  output  width  RAM write data. Continuous combinational pass-through of mem_rd.
- mem_rd  input  width  RAM read data. Registered in the RAM; valid the cycle after the address is presented.

Behaviour:
- States: IDLE, RD, WR, DONE. mem_add, mem_we, busy and done are decoded from registered state and pointers only. No combinational path from start to the mem outputs.
- Reset (rst=1 sampled at an edge) forces: state=IDLE, busy=0, done=0, mem_we=0, mem_add=0, and clears the rptr/wptr/cnt registers.
- IDLE: mem_we=0, mem_add=0. On an edge with start=1:
  - len=0 -> DONE.
  - otherwise -> RD, with cnt=len and the direction latched.
- Direction: let d = (dst - src) mod 2^add_width.
  - If 1 <= d <= len-1: descending. rptr=src+len-1, wptr=dst+len-1, step -1.
  - Otherwise: ascending. rptr=src, wptr=dst, step +1.
  - src==dst is ascending; the copy is performed normally, with no shortcut.
- RD (1 cycle): mem_add=rptr, mem_we=0, busy=1. RAM captures mem[rptr] into rd at the end of this cycle. Next state: WR.
- WR (1 cycle): mem_add=wptr, mem_we=1, mem_wr=mem_rd (the word read in the preceding RD), busy=1. At the edge:
  - rptr and wptr step by ±1, wrapping modulo 2^add_width.
  - cnt decrements.
  - If cnt was 1 -> DONE, else -> RD.
- DONE (1 cycle): done=1, busy=0, mem_we=0, mem_add=0. Next state: IDLE.
- Throughput and latency: 2 cycles per word. For len=N>0 with start sampled at edge e0:
  - busy is high for 2N cycles following e0.
  - done is high in cycle 2N+1.
  - For len=0, done is high in the cycle right after e0.
- start asserted outside IDLE (RD/WR/DONE) is ignored and not queued.
- Inputs src/dst/len are sampled only at the accepting edge. Later changes have no effect on a copy in progress.
- Wrap-around: a block crossing address 2^add_width-1 continues at 0; the same applies to 0 -> max when descending.
- len maximum is 2^add_width-1.
- Reset mid-operation:
  - If rst is sampled at the edge ending a WR cycle, that single write still lands, because the RAM samples we=1 at the same edge.
  - No further RAM accesses occur; state goes to IDLE and done is not pulsed.
- No RAM write occurs in IDLE, DONE or RD, ever.

Test Plan:
- Ascending copy: preload mem[0x0100..0x0103]=A1,A2,A3,A4; start src=0x0100 dst=0x0200 len=4.
  - Required: mem[0x0200..0x0203]=A1..A4.
  - busy high 8 cycles; done in cycle 9.
  - mem_add sequence 0100,0200,0101,0201,...
- Overlap descending: mem[0x10..0x14]=1,2,3,4,5; src=0x10 dst=0x12 len=5.
  - Required: mem[0x12..0x16]=1,2,3,4,5.
  - First access mem_add=0x14 (read), then 0x16 (write).
- Overlap ascending: same preload; src=0x12 dst=0x10 len=3.
  - Required: mem[0x10..0x12]=3,4,5; mem[0x13..0x14] unchanged (4,5).
- Wrap and no-op:
  - src=0x1FFE dst=0x0010 len=3 -> mem[0x10..0x12]=mem[0x1FFE],mem[0x1FFF],mem[0x0000].
  - len=0 -> done one cycle after start, busy never high, mem_we never high.
- Start while busy: pulse start again with different src during the copy -> ignored; only the original copy is performed; exactly one done pulse.
- Reset mid-copy: assert rst for one edge at the end of the 2nd WR of a len=4 copy.
  - Required: exactly 2 destination words written; busy=0, done=0, mem_we=0 after the edge.
  - A subsequent start runs normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine
// Description : memmove-style block copier that drives a single-port
//               synchronous RAM (1-cycle registered read).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int WIDTH     = 16,
    parameter int ADD_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_WIDTH-1:0] src,
    input  logic [ADD_WIDTH-1:0] dst,
    input  logic [ADD_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_we,
    output logic [ADD_WIDTH-1:0] mem_add,
    output logic [WIDTH-1:0]     mem_wr,
    input  logic [WIDTH-1:0]     mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADD_WIDTH-1:0] c_ONE = ADD_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADD_WIDTH-1:0]   r_rptr;
    logic [ADD_WIDTH-1:0]   r_wptr;
    logic [ADD_WIDTH-1:0]   r_cnt;
    logic                   r_desc;
    logic [ADD_WIDTH-1:0]   w_rptr_nxt;
    logic [ADD_WIDTH-1:0]   w_wptr_nxt;
    logic [ADD_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_desc_nxt;

    logic [ADD_WIDTH-1:0]   w_dist;
    logic [ADD_WIDTH-1:0]   w_len_m1;
    logic                   w_overlap;

    // Destination starts inside the source block: copy from the top down so
    // no source word is overwritten before it has been read.
    assign w_dist    = dst - src;
    assign w_len_m1  = len - c_ONE;
    assign w_overlap = (w_dist != '0) && (w_dist <= w_len_m1);

    // The RAM's read data is the write data; WR always follows its RD.
    assign mem_wr = mem_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_desc  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rptr  <= w_rptr_nxt;
            r_wptr  <= w_wptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_desc  <= w_desc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rptr_nxt  = r_rptr;
        w_wptr_nxt  = r_wptr;
        w_cnt_nxt   = r_cnt;
        w_desc_nxt  = r_desc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RD;
                        w_cnt_nxt   = len;
                        w_desc_nxt  = w_overlap;
                        if (w_overlap) begin
                            w_rptr_nxt = src + w_len_m1;
                            w_wptr_nxt = dst + w_len_m1;
                        end else begin
                            w_rptr_nxt = src;
                            w_wptr_nxt = dst;
                        end
                    end
                end
            end
            S_RD: begin
                w_state_nxt = S_WR;
            end
            S_WR: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_desc) begin
                    w_rptr_nxt = r_rptr - c_ONE;
                    w_wptr_nxt = r_wptr - c_ONE;
                end else begin
                    w_rptr_nxt = r_rptr + c_ONE;
                    w_wptr_nxt = r_wptr + c_ONE;
                end
                w_state_nxt = (r_cnt == c_ONE) ? S_DONE : S_RD;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state so start never reaches the RAM.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_we  = 1'b0;
        mem_add = '0;
        case (r_state)
            S_RD: begin
                busy    = 1'b1;
                mem_add = r_rptr;
            end
            S_WR: begin
                busy    = 1'b1;
                mem_we  = 1'b1;
                mem_add = r_wptr;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Directed self-checking bench for mem_copy_engine with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] src = '0;
    logic [12:0] dst = '0;
    logic [12:0] len = '0;
    logic        busy, done, mem_we;
    logic [12:0] mem_add;
    logic [15:0] mem_wr;
    logic [15:0] mem_rd = '0;

    logic [15:0] ram [0:8191];
    logic [12:0] addr_log [$];

    int n_checks = 0;
    int n_fail   = 0;
    int b_n, d_c, d_n, w_n;

    mem_copy_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .mem_we  (mem_we),
        .mem_add (mem_add),
        .mem_wr  (mem_wr),
        .mem_rd  (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_add] <= mem_wr;
        mem_rd <= ram[mem_add];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one copy and observe it cycle by cycle (cycle k = k-th after accept).
    task automatic run_copy(input logic [12:0] s, input logic [12:0] d, input logic [12:0] l,
                            input int restart_cyc, input int rst_cyc,
                            output int busy_n, output int done_cyc, output int done_n, output int we_n);
        int budget;
        busy_n = 0; done_cyc = 0; done_n = 0; we_n = 0;
        addr_log.delete();
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        budget = 2 * int'(l) + 8;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (mem_we) we_n++;
            if (busy || mem_we) addr_log.push_back(mem_add);
            if (rst_cyc != 0 && k == rst_cyc + 1) begin
                check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_mid_done", {31'd0, done}, 32'd0);
                check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
                rst = 1'b0;
            end
            if (rst_cyc != 0 && k == rst_cyc) rst = 1'b1;
            if (restart_cyc != 0 && k == restart_cyc) begin
                start = 1'b1; src = 13'h0500; dst = 13'h0600; len = 13'd7;
            end
            if (restart_cyc != 0 && k == restart_cyc + 1) start = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_we", {31'd0, mem_we}, 32'd0);
        check_eq("reset_add", {19'd0, mem_add}, 32'd0);
        rst = 1'b0;

        // Ascending, disjoint
        ram[13'h0100] = 16'h00A1; ram[13'h0101] = 16'h00A2;
        ram[13'h0102] = 16'h00A3; ram[13'h0103] = 16'h00A4;
        run_copy(13'h0100, 13'h0200, 13'd4, 0, 0, b_n, d_c, d_n, w_n);
        check_eq("asc_busy_cycles", b_n, 8);
        check_eq("asc_done_cycle", d_c, 9);
        check_eq("asc_done_count", d_n, 1);
        check_eq("asc_writes", w_n, 4);
        check_eq("asc_log_len", addr_log.size(), 8);
        if (addr_log.size() >= 4) begin
            check_eq("asc_add0", {19'd0, addr_log[0]}, 32'h0100);
            check_eq("asc_add1", {19'd0, addr_log[1]}, 32'h0200);
            check_eq("asc_add2", {19'd0, addr_log[2]}, 32'h0101);
            check_eq("asc_add3", {19'd0, addr_log[3]}, 32'h0201);
        end
        check_eq("asc_m0", {16'd0, ram[13'h0200]}, 32'h00A1);
        check_eq("asc_m1", {16'd0, ram[13'h0201]}, 32'h00A2);
        check_eq("asc_m2", {16'd0, ram[13'h0202]}, 32'h00A3);
        check_eq("asc_m3", {16'd0, ram[13'h0203]}, 32'h00A4);

        // Overlap, dst above src: descending
        for (int i = 0; i < 7; i++) ram[13'h10 + i] = (i < 5) ? 16'(i + 1) : 16'h0000;
        run_copy(13'h0010, 13'h0012, 13'd5, 0, 0, b_n, d_c, d_n, w_n);
        check_eq("desc_done_cycle", d_c, 11);
        if (addr_log.size() >= 2) begin
            check_eq("desc_first_rd", {19'd0, addr_log[0]}, 32'h0014);
            check_eq("desc_first_wr", {19'd0, addr_log[1]}, 32'h0016);
        end else check_eq("desc_log_len", addr_log.size(), 10);
        for (int i = 0; i < 5; i++) check_eq("desc_mem", {16'd0, ram[13'h12 + i]}, i + 1);

        // Overlap, dst below src: ascending
        for (int i = 0; i < 5; i++) ram[13'h10 + i] = 16'(i + 1);
        run_copy(13'h0012, 13'h0010, 13'd3, 0, 0, b_n, d_c, d_n, w_n);
        check_eq("ovasc_m10", {16'd0, ram[13'h10]}, 3);
        check_eq("ovasc_m11", {16'd0, ram[13'h11]}, 4);
        check_eq("ovasc_m12", {16'd0, ram[13'h12]}, 5);
        check_eq("ovasc_m13", {16'd0, ram[13'h13]}, 4);
        check_eq("ovasc_m14", {16'd0, ram[13'h14]}, 5);

        // Wrap across the top of the address space
        ram[13'h1FFE] = 16'h1111; ram[13'h1FFF] = 16'h2222; ram[13'h0000] = 16'h3333;
        run_copy(13'h1FFE, 13'h0010, 13'd3, 0, 0, b_n, d_c, d_n, w_n);
        if (addr_log.size() >= 5) check_eq("wrap_add4", {19'd0, addr_log[4]}, 32'h0000);
        else check_eq("wrap_log_len", addr_log.size(), 6);
        check_eq("wrap_m10", {16'd0, ram[13'h10]}, 32'h1111);
        check_eq("wrap_m11", {16'd0, ram[13'h11]}, 32'h2222);
        check_eq("wrap_m12", {16'd0, ram[13'h12]}, 32'h3333);

        // len = 0 no-op
        run_copy(13'h0100, 13'h0300, 13'd0, 0, 0, b_n, d_c, d_n, w_n);
        check_eq("nop_done_cycle", d_c, 1);
        check_eq("nop_done_count", d_n, 1);
        check_eq("nop_busy", b_n, 0);
        check_eq("nop_we", w_n, 0);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) begin
            ram[13'h0300 + i] = 16'hB000 + 16'(i);
            ram[13'h0500 + i] = 16'hC000 + 16'(i);
            ram[13'h0400 + i] = 16'h0000;
            ram[13'h0600 + i] = 16'h0000;
        end
        run_copy(13'h0300, 13'h0400, 13'd3, 3, 0, b_n, d_c, d_n, w_n);
        check_eq("sb_done_count", d_n, 1);
        check_eq("sb_done_cycle", d_c, 7);
        check_eq("sb_writes", w_n, 3);
        for (int i = 0; i < 3; i++) check_eq("sb_mem", {16'd0, ram[13'h0400 + i]}, 32'hB000 + i);
        check_eq("sb_alt_untouched", {16'd0, ram[13'h0600]}, 0);

        // Reset at the edge ending the second WR
        for (int i = 0; i < 4; i++) begin
            ram[13'h0700 + i] = 16'h7000 + 16'(i);
            ram[13'h0800 + i] = 16'hDEAD;
        end
        run_copy(13'h0700, 13'h0800, 13'd4, 0, 4, b_n, d_c, d_n, w_n);
        check_eq("rst_writes", w_n, 2);
        check_eq("rst_done_count", d_n, 0);
        check_eq("rst_m0", {16'd0, ram[13'h0800]}, 32'h7000);
        check_eq("rst_m1", {16'd0, ram[13'h0801]}, 32'h7001);
        check_eq("rst_m2", {16'd0, ram[13'h0802]}, 32'hDEAD);
        check_eq("rst_m3", {16'd0, ram[13'h0803]}, 32'hDEAD);

        run_copy(13'h0702, 13'h0802, 13'd2, 0, 0, b_n, d_c, d_n, w_n);
        check_eq("post_rst_done_cycle", d_c, 5);
        check_eq("post_rst_m2", {16'd0, ram[13'h0802]}, 32'h7002);
        check_eq("post_rst_m3", {16'd0, ram[13'h0803]}, 32'h7003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
